// File: rtl/mult_pkg.sv
// mult_pkg: shared sequencer state encoding and default operand width
package mult_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, OP, SHIFT, DONE} seq_state_t;
  localparam int MULT_WIDTH_DEFAULT = 8;
endpackage

// File: rtl/mult_bit_counter.sv
// mult_bit_counter: iteration counter with sync clear, enable and terminal-count flag
module mult_bit_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Saturates at WIDTH-1 so the index never wraps
  always_comb cnt_d = clr ? '0 : (en && !last) ? cnt_q + CNT_W'(1) : cnt_q;
  always_ff @(posedge clk) cnt_q <= cnt_d;
  assign cnt  = cnt_q;
  assign last = cnt_q == CNT_W'(WIDTH - 1);
endmodule

// File: rtl/mult_sequencer.sv
// mult_sequencer: valid/ready sequencer stepping a shift-add signed multiplier datapath
module mult_sequencer
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH_DEFAULT,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             M,
  output logic             Ld_S,
  output logic             Ld_B,
  output logic             Clr_XA,
  output logic             Add,
  output logic             Sub,
  output logic             Shift_En,
  output logic             busy,
  output logic [CNT_W-1:0] bit_idx
);
  seq_state_t state_q, state_d;
  logic       last;
  mult_bit_counter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_cnt (
    .clk (Clk),
    .clr (!Reset || state_q == LOAD),
    .en  (state_q == SHIFT),
    .cnt (bit_idx),
    .last(last)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = in_valid ? LOAD : IDLE;
      LOAD:    state_d = OP;
      OP:      state_d = SHIFT;
      SHIFT:   state_d = last ? DONE : OP;
      DONE:    state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
    in_ready  = state_q == IDLE;
    out_valid = state_q == DONE;
    Ld_S      = state_q == LOAD;
    Ld_B      = state_q == LOAD;
    Clr_XA    = state_q == LOAD;
    // The final iteration weighs the multiplier sign bit negatively
    Add       = state_q == OP && M && !last;
    Sub       = state_q == OP && M && last;
    Shift_En  = state_q == SHIFT;
    busy      = state_q == LOAD || state_q == OP || state_q == SHIFT || state_q == DONE;
  end
  always_ff @(posedge Clk) state_q <= !Reset ? IDLE : state_d;
endmodule

// File: tb/tb_mult_sequencer.sv
// tb_mult_sequencer: directed checks of the sequencer driving a bench-side datapath model
module tb_mult_sequencer;
  logic       Clk = 0, Reset = 0, in_valid = 0, out_ready = 0, M = 0;
  logic       in_ready, out_valid, Ld_S, Ld_B, Clr_XA, Add, Sub, Shift_En, busy;
  logic [2:0] bit_idx;
  logic       x = 0;
  logic [7:0] a = 0, b = 0, s = 0, bus_s = 0, bus_b = 0;
  int         n_cmp = 0, n_bad = 0;

  mult_sequencer #(.WIDTH(8)) dut (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .M(M), .Ld_S(Ld_S), .Ld_B(Ld_B),
    .Clr_XA(Clr_XA), .Add(Add), .Sub(Sub), .Shift_En(Shift_En), .busy(busy), .bit_idx(bit_idx)
  );

  always #5 Clk = ~Clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle, applying this cycle's strobes to the X:A:B model
  task automatic tick();
    logic ls, lb, cl, ad, sb, sh;
    ls = Ld_S; lb = Ld_B; cl = Clr_XA; ad = Add; sb = Sub; sh = Shift_En;
    @(posedge Clk);
    #1;
    if (cl) begin x = 0; a = 0; end
    if (ls) s = bus_s;
    if (lb) b = bus_b;
    if (ad) {x, a} = {a[7], a} + {s[7], s};
    if (sb) {x, a} = {a[7], a} - {s[7], s};
    if (sh) begin b = {a[0], b[7:1]}; a = {x, a[7:1]}; end
    M = b[0];
    #1;
    check("add_sub_excl", {31'd0, Add && Sub}, 0);
    check("shift_excl", {31'd0, Shift_En && (Add || Sub)}, 0);
    check("ldb_only_load", {31'd0, Ld_B && !(Ld_S && Clr_XA && busy && !in_ready)}, 0);
  endtask

  task automatic run(logic [7:0] op_s, logic [7:0] op_b, int hold,
                     logic [7:0] exp_add, logic [7:0] exp_sub, logic [15:0] exp_prod);
    int lat, nsh, nld;
    logic [7:0] add_m, sub_m;
    bus_s = op_s; bus_b = op_b; out_ready = 0; in_valid = 1;
    check("idle_ready", {31'd0, in_ready}, 1);
    tick();
    in_valid = 0;
    lat = 1; nsh = 0; nld = 0; add_m = 0; sub_m = 0;
    while (!out_valid && lat < 60) begin
      if (Add) add_m = add_m | (8'd1 << bit_idx);
      if (Sub) sub_m = sub_m | (8'd1 << bit_idx);
      if (Shift_En) nsh++;
      if (Ld_B) nld++;
      tick();
      lat++;
    end
    check("latency", lat, 18);
    check("add_mask", {24'd0, add_m}, {24'd0, exp_add});
    check("sub_mask", {24'd0, sub_m}, {24'd0, exp_sub});
    check("shift_cnt", nsh, 8);
    check("load_cnt", nld, 1);
    check("product", {16'd0, a, b}, {16'd0, exp_prod});
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", {31'd0, out_valid}, 1);
      check("hold_strobes", {26'd0, Ld_S, Ld_B, Clr_XA, Add, Sub, Shift_En}, 0);
      tick();
    end
    check("done_valid", {31'd0, out_valid}, 1);
    out_ready = 1;
    tick();
    out_ready = 0;
    check("retire_idle", {29'd0, in_ready, out_valid, busy}, 3'b100);
  endtask

  initial begin
    int loads, last_ld, viol;
    tick();
    tick();
    Reset = 1;
    check("rst_state", {29'd0, in_ready, busy, out_valid}, 3'b100);
    check("rst_strobes", {26'd0, Ld_S, Ld_B, Clr_XA, Add, Sub, Shift_En}, 0);
    check("rst_idx", {29'd0, bit_idx}, 0);

    // Abandon an operation mid-OP with a two-cycle reset
    bus_s = 8'h05; bus_b = 8'h03; in_valid = 1;
    tick();
    in_valid = 0;
    for (int i = 0; i < 4; i++) tick();
    check("pre_rst_busy", {31'd0, busy}, 1);
    Reset = 0;
    tick();
    tick();
    Reset = 1;
    check("abort_state", {29'd0, in_ready, busy, out_valid}, 3'b100);
    check("abort_strobes", {26'd0, Ld_S, Ld_B, Clr_XA, Add, Sub, Shift_En}, 0);
    check("abort_idx", {29'd0, bit_idx}, 0);
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid || !in_ready) viol++;
    end
    check("abort_no_valid", viol, 0);

    run(8'h05, 8'h03, 0, 8'h03, 8'h00, 16'h000F);
    run(8'h02, 8'h80, 5, 8'h00, 8'h80, 16'hFF00);
    run(8'hFD, 8'hFB, 0, 8'h7B, 8'h80, 16'h000F);
    run(8'h7F, 8'h7F, 1, 8'h7F, 8'h00, 16'h3F01);

    // Back-to-back requests with in_valid and out_ready held high
    in_valid = 1; out_ready = 1; loads = 0; last_ld = -1; viol = 0;
    for (int i = 1; i <= 57; i++) begin
      tick();
      if (in_ready && busy) viol++;
      if (Ld_B) begin
        if (last_ld >= 0) check("load_spacing", i - last_ld, 19);
        last_ld = i;
        loads++;
      end
    end
    in_valid = 0; out_ready = 0;
    check("load_count", loads, 3);
    check("ready_vs_busy", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
